pipeline_stage_tracker: RTL
===========================

Name: pipeline_stage_tracker

Overview:
- Sequential counterpart to the combinational hazard checker.
- Each cycle it consumes STALL from the hazard checker, branch FLUSH from EX and MEM_BUSY from memory. It returns the per-stage RD/RD_USED/OP metadata the checker compares against.
- It tracks destination metadata for the EX, ME and WB stages, inserts bubbles on stall or flush, and drives the pipeline-register enables and clears.
- It also keeps saturating stall/flush counters and a stall-watchdog error flag.

Parameters:
- CNT_W, 16, width of the STALL_CNT and FLUSH_CNT performance counters.
- MAX_STALL, 4, number of consecutive stall cycles after which STALL_ERR sets.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous reset, active low.
- DE_VALID  in  1  the DE-stage instruction is valid.
- DE_IR  in  32  instruction currently in DE.
- STALL  in  1  stall request from the hazard checker.
- FLUSH  in  1  taken branch or jump resolved in EX.
- MEM_BUSY  in  1  data memory is not ready; the whole pipeline freezes.
- PC_WE  out  1  PC write enable.
- IF_DE_WE  out  1  IF/DE register write enable.
- IF_DE_CLR  out  1  IF/DE register clear (kills the DE instruction).
- DE_EX_CLR  out  1  DE/EX register load-bubble.
- RD_EX, RD_ME, RD_WB  out  5 each  destination register per stage.
- RD_USED_EX, RD_USED_ME, RD_USED_WB  out  1 each  the stage writes a nonzero rd.
- OP_EX, OP_ME, OP_WB  out  7 each  opcode per stage.
- STALL_CNT  out  CNT_W  count of stall cycles.
- FLUSH_CNT  out  CNT_W  count of flush events.
- STALL_ERR  out  1  sticky watchdog flag.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All stage metadata is cleared: RD=0, RD_USED=0, OP=7'b0000000, internal valid bits=0.
  - Both counters=0, STALL_ERR=0, stall-run counter=0.
  - PC_WE, IF_DE_WE, IF_DE_CLR and DE_EX_CLR are forced to 0 while RST_N is low.
  - Reset takes effect mid-operation with no completion of in-flight state.
- Decode of DE_IR (combinational):
  - opcode=DE_IR[6:0], rd=DE_IR[11:7].
  - The instruction writes rd for opcodes 0110111, 0010111, 1101111, 1100111, 0000011, 0010011 and 0110011.
  - It also writes rd for 1110011 when funct3 (DE_IR[14:12]) is not 000.
  - BRANCH, STORE and unknown opcodes do not write rd.
  - de_rd_used = DE_VALID AND writes-rd AND (rd != 0).
- Enables (combinational), priority MEM_BUSY > FLUSH > STALL:
  - MEM_BUSY=1: PC_WE=IF_DE_WE=IF_DE_CLR=DE_EX_CLR=0. No stage state changes, counters and watchdog hold.
  - FLUSH=1: PC_WE=1, IF_DE_WE=1, IF_DE_CLR=1, DE_EX_CLR=1. STALL is ignored.
  - STALL=1: PC_WE=0, IF_DE_WE=0, IF_DE_CLR=0, DE_EX_CLR=1.
  - Otherwise: PC_WE=1, IF_DE_WE=1, IF_DE_CLR=0, DE_EX_CLR=!DE_VALID.
- Stage advance (rising edge, only when MEM_BUSY=0):
  - WB<=ME and ME<=EX.
  - If DE_EX_CLR, EX<=bubble (valid=0, RD=0, RD_USED=0, OP=0).
  - Otherwise EX<={rd, de_rd_used, opcode}.
- Output gating: each RD_USED_x is registered and is 0 for bubbles. No further gating is applied.
- Latency: an instruction's metadata appears on the *_EX outputs 1 cycle after it leaves DE, on *_ME after 2 cycles and on *_WB after 3 cycles.
- STALL_CNT increments on each edge with STALL=1, FLUSH=0, MEM_BUSY=0. It saturates at all-ones with no wrap.
- FLUSH_CNT increments on each edge with FLUSH=1, MEM_BUSY=0. It saturates.
- Watchdog:
  - A run counter increments on each counted stall edge and clears on any edge with MEM_BUSY=0 and STALL=0.
  - When the run counter reaches MAX_STALL, STALL_ERR<=1.
  - STALL_ERR is sticky until reset, and the run counter saturates at MAX_STALL.
- Simultaneous FLUSH and STALL: treated as a flush. The run counter clears.

Test Plan:
- Reset, then release RST_N with DE_VALID=1 and DE_IR=ADDI x5,x0,1 (32'h00100293), no stall → after 1 edge RD_EX=5, RD_USED_EX=1, OP_EX=7'h13. After 3 edges RD_WB=5. The counters stay 0.
- LW x6 in EX, then STALL=1 for 1 cycle with ADD x7,x6,x1 in DE → PC_WE=0, IF_DE_WE=0, DE_EX_CLR=1. The next edge gives an EX bubble (RD_USED_EX=0, OP_EX=0) and RD_ME=6. STALL_CNT=1.
- STALL and FLUSH both 1 → IF_DE_CLR=1, PC_WE=1. The EX bubble lands on the edge. FLUSH_CNT=1, STALL_CNT unchanged.
- MEM_BUSY=1 for 3 cycles with STALL=1 → all enables 0 and the stage outputs are frozen bit-for-bit. STALL_CNT and the run counter are unchanged.
- Boundary cases:
  - ADDI x0,x0,0 gives RD_USED_EX=0.
  - CSRRW x3 (funct3=001) gives RD_USED_EX=1.
  - ECALL (funct3=000) gives RD_USED_EX=0.
  - BEQ and SW give RD_USED_EX=0.
- STALL held for 4 consecutive cycles with MAX_STALL=4 → STALL_ERR=1 after the 4th edge. It stays 1 after STALL drops and clears only on RST_N=0. Separately, with CNT_W=2, 5 stall cycles leave STALL_CNT=3.

Source files
------------

// File: rtl/pipeline_stage_tracker_if.sv
// Handshake bundle between the core's hazard/control logic and the stage tracker.
// The tracker sees the DE instruction and the hazard/memory requests, and returns the enables and per-stage metadata.
interface pipeline_stage_tracker_if;
    logic        de_valid;
    logic [31:0] de_ir;
    logic        stall;
    logic        flush;
    logic        mem_busy;

    logic        pc_we;
    logic        if_de_we;
    logic        if_de_clr;
    logic        de_ex_clr;

    logic [4:0]  rd_ex;
    logic [4:0]  rd_me;
    logic [4:0]  rd_wb;
    logic        rd_used_ex;
    logic        rd_used_me;
    logic        rd_used_wb;
    logic [6:0]  op_ex;
    logic [6:0]  op_me;
    logic [6:0]  op_wb;

    modport master (
        output de_valid, de_ir, stall, flush, mem_busy,
        input  pc_we, if_de_we, if_de_clr, de_ex_clr,
        input  rd_ex, rd_me, rd_wb,
        input  rd_used_ex, rd_used_me, rd_used_wb,
        input  op_ex, op_me, op_wb
    );

    modport slave (
        input  de_valid, de_ir, stall, flush, mem_busy,
        output pc_we, if_de_we, if_de_clr, de_ex_clr,
        output rd_ex, rd_me, rd_wb,
        output rd_used_ex, rd_used_me, rd_used_wb,
        output op_ex, op_me, op_wb
    );
endinterface

// File: rtl/pipeline_stage_tracker.sv
// Tracks rd/rd_used/opcode for the EX, ME and WB stages and drives the pipeline-register enables.
// It also keeps saturating stall/flush counters and a sticky watchdog for long stall runs.
module pipeline_stage_tracker #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipeline_stage_tracker_if.slave  pipe,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt,
    output logic                     stall_err
);

    localparam int                RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL);

    logic [6:0]       de_op;
    logic [4:0]       de_rd;
    logic [2:0]       de_funct3;
    logic             writes_rd;
    logic             de_rd_used;
    logic             de_ex_clr;
    logic [RUN_W-1:0] run_cnt;
    logic             unused_ir;

    assign unused_ir = ^pipe.de_ir[31:15];

    always_comb begin
        de_op     = pipe.de_ir[6:0];
        de_rd     = pipe.de_ir[11:7];
        de_funct3 = pipe.de_ir[14:12];
        writes_rd = 1'b0;
        case (de_op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0000011, 7'b0010011, 7'b0110011: writes_rd = 1'b1;
            // SYSTEM writes rd only for the CSR forms; ECALL/EBREAK have funct3 000
            7'b1110011:                         writes_rd = (de_funct3 != 3'b000);
            default:                            writes_rd = 1'b0;
        endcase
        de_rd_used = pipe.de_valid && writes_rd && (de_rd != 5'd0);
    end

    // Enables are held low for the whole reset window so nothing upstream advances.
    always_comb begin
        pipe.pc_we     = 1'b0;
        pipe.if_de_we  = 1'b0;
        pipe.if_de_clr = 1'b0;
        de_ex_clr      = 1'b0;
        if (rst_n) begin
            if (pipe.mem_busy) begin
                de_ex_clr = 1'b0;
            end else if (pipe.flush) begin
                pipe.pc_we     = 1'b1;
                pipe.if_de_we  = 1'b1;
                pipe.if_de_clr = 1'b1;
                de_ex_clr      = 1'b1;
            end else if (pipe.stall) begin
                de_ex_clr = 1'b1;
            end else begin
                pipe.pc_we    = 1'b1;
                pipe.if_de_we = 1'b1;
                de_ex_clr     = !pipe.de_valid;
            end
        end
        pipe.de_ex_clr = de_ex_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.rd_ex      <= 5'd0;
            pipe.rd_me      <= 5'd0;
            pipe.rd_wb      <= 5'd0;
            pipe.rd_used_ex <= 1'b0;
            pipe.rd_used_me <= 1'b0;
            pipe.rd_used_wb <= 1'b0;
            pipe.op_ex      <= 7'd0;
            pipe.op_me      <= 7'd0;
            pipe.op_wb      <= 7'd0;
        end else if (!pipe.mem_busy) begin
            pipe.rd_wb      <= pipe.rd_me;
            pipe.rd_used_wb <= pipe.rd_used_me;
            pipe.op_wb      <= pipe.op_me;
            pipe.rd_me      <= pipe.rd_ex;
            pipe.rd_used_me <= pipe.rd_used_ex;
            pipe.op_me      <= pipe.op_ex;
            if (de_ex_clr) begin
                pipe.rd_ex      <= 5'd0;
                pipe.rd_used_ex <= 1'b0;
                pipe.op_ex      <= 7'd0;
            end else begin
                pipe.rd_ex      <= de_rd;
                pipe.rd_used_ex <= de_rd_used;
                pipe.op_ex      <= de_op;
            end
        end
    end

    // A flush wins over a simultaneous stall, so it is not counted as a stall and breaks the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            run_cnt   <= '0;
            stall_err <= 1'b0;
        end else if (!pipe.mem_busy) begin
            if (pipe.flush) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                run_cnt <= '0;
            end else if (pipe.stall) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_W'(1);
                if (run_cnt >= RUN_MAX - RUN_W'(1)) stall_err <= 1'b1;
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule
